fifo_mac_array: RTL
===================

Name: fifo_mac_array

Overview:
- Parametrised successor to the single-lane FIFO-plus-MAC board datapath.
- LANES row FIFOs (operand A) and one shared vector FIFO (operand B) are loaded through one write port.
- On start, all FIFOs drain in lock-step. Each lane computes a dot product sum(A_i[k]*B[k]) over DEPTH entries.
- Sits between the switch/key control logic and the HEX/LED display logic of the minilab top level.

Parameters:
- DATA_WIDTH, 8: operand width in bits.
- DEPTH, 8: entries per FIFO, which is also the dot-product length (power of 2, >=2).
- LANES, 8: number of A FIFOs and accumulators (>=1).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(DEPTH): accumulator width. Derived; do not override.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  write request.
- in_sel  in  $clog2(LANES+1)  target FIFO: 0..LANES-1 = A lanes, LANES = B FIFO.
- in_data  in  DATA_WIDTH  write data.
- in_ready  out  1  write accepted this cycle when in_valid & in_ready.
- start  in  1  begin compute (single-cycle pulse or level).
- clr  in  1  clear results and return to IDLE.
- busy  out  1  high in EXEC.
- done  out  1  high in DONE.
- all_full  out  1  every FIFO holds DEPTH entries.
- result  out  LANES*ACC_WIDTH  lane i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- Reset (asynchronous, any state, including mid-EXEC):
  - state=IDLE; all FIFO counts and pointers = 0; accumulators, product registers and the pipeline valid bit = 0.
  - busy=0, done=0, all_full=0, result=0.
  - in_ready resolves to 1 for any valid in_sel once rst_n deasserts.
- States: IDLE, EXEC, DONE. Loading happens in IDLE; there is no separate fill state.
- in_ready (combinational) = (state==IDLE) & (in_sel<=LANES) & (count[in_sel]<DEPTH).
- Write to a full FIFO: in_ready=0, data dropped, count unchanged.
- Write with in_sel > LANES: in_ready=0, data dropped.
- all_full is registered. It reflects FIFO counts as of the previous edge.
- IDLE -> EXEC: only when start=1 and every FIFO count==DEPTH. A start with any FIFO not full is ignored and the state stays IDLE.
- EXEC pipeline:
  - Cycle counter k runs 0..DEPTH-1. Each cycle pops the head of every FIFO simultaneously.
  - Stage 1 registers prod_i = A_i*B (unsigned, 2*DATA_WIDTH bits).
  - Stage 2 adds prod_i, zero-extended, into acc_i.
  - Sized by ACC_WIDTH, so no overflow is possible.
  - Read pointers wrap modulo DEPTH.
- EXEC -> DONE: after the last product is accumulated. done rises DEPTH+2 rising edges after the edge that accepted start. busy is high for exactly those DEPTH+2 cycles.
- DONE: result holds; start and writes are ignored (in_ready=0). FIFOs are empty.
- clr:
  - In DONE or IDLE, takes effect on the next edge: accumulators = 0, state = IDLE, done = 0.
  - In IDLE, clr also leaves FIFO contents untouched.
  - clr in EXEC is ignored.
- result is driven straight from the accumulators. During EXEC it shows partial sums, which are not valid until done=1.
- Simultaneous start and clr in IDLE: clr wins, and start is ignored for that cycle.

Optional Feature:
- Macro: FIFO_MAC_SIGNED_EN.
- Defined: A and B are two's complement. Products are signed, and they are sign-extended into signed accumulators. result is two's complement in ACC_WIDTH bits.
- Undefined: all arithmetic is unsigned, as described in Behaviour.
- Latency and handshakes are identical in both builds.

Test Plan (defaults DATA_WIDTH=8, DEPTH=8, LANES=8):
- Reset with rst_n=0 for 3 cycles, release -> busy=0, done=0, all_full=0, result=0, in_ready=1 for in_sel=0.
- Load B=1..8 and every A_i with value i+1, then start -> busy for 10 cycles, then done=1, lane i result = 36*(i+1) (lane 0 = 0x24, lane 7 = 0x120).
- Load all FIFOs with 0xFF, then start -> every lane = 0x7F008 (520200), no wrap in 19 bits.
- Lane 0 accepts 8 writes; 9th write -> in_ready=0, count stays 8. Start while B is empty -> ignored, busy stays 0.
- Assert rst_n=0 at EXEC cycle 4 -> immediately busy=0, result=0. Reload and rerun -> correct sums. clr in DONE -> done=0, result=0, state IDLE.
- With FIFO_MAC_SIGNED_EN defined: A=0xFF (-1), B=0x02, all entries -> every lane = 0x7FFF0 (-16).

Source files
------------

// File: rtl/fifo_mac_array.sv
// fifo_mac_array: LANES operand-A row FIFOs plus one shared operand-B FIFO,
// loaded through a single write port and drained in lock-step into
// LANES two-stage multiply-accumulate pipelines (one dot product per lane).
// Optional build macro: FIFO_MAC_SIGNED_EN selects two's-complement
// operands, products and accumulators. When it is undefined, all
// arithmetic is unsigned.
module fifo_mac_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LANES      = 8,
  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [$clog2(LANES+1)-1:0]     in_sel,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  input  logic                           start,
  input  logic                           clr,
  output logic                           busy,
  output logic                           done,
  output logic                           all_full,
  output logic [LANES*ACC_WIDTH-1:0]     result
);

  localparam int unsigned NF     = LANES + 1;
  localparam int unsigned SEL_W  = $clog2(LANES + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned K_W    = $clog2(DEPTH + 2);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned EXT_W  = ACC_WIDTH - PROD_W;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem    [NF][DEPTH];
  logic [PTR_W-1:0]        wr_ptr [NF];
  logic [PTR_W-1:0]        rd_ptr [NF];
  logic [CNT_W-1:0]        cnt    [NF];
  logic [K_W-1:0]          k;
  logic                    pvalid;
  logic [PROD_W-1:0]       prod   [LANES];
  logic [ACC_WIDTH-1:0]    acc    [LANES];
  logic [PROD_W-1:0]       a_ext  [LANES];
  logic [PROD_W-1:0]       b_ext;
  logic                    fifos_full_c;
  logic                    pop_c;
  logic                    acc_clr_c;
  logic                    wr_en_c;

  // Widen an operand to product width (sign- or zero-extension by build).
  function automatic logic [PROD_W-1:0] op_ext(input logic [DATA_WIDTH-1:0] x);
`ifdef FIFO_MAC_SIGNED_EN
    return {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
`else
    return {{DATA_WIDTH{1'b0}}, x};
`endif
  endfunction

  // Widen a product to accumulator width (sign- or zero-extension by build).
  function automatic logic [ACC_WIDTH-1:0] prod_ext(input logic [PROD_W-1:0] p);
`ifdef FIFO_MAC_SIGNED_EN
    return {{EXT_W{p[PROD_W-1]}}, p};
`else
    return {{EXT_W{1'b0}}, p};
`endif
  endfunction

  // Every FIFO (A lanes and B) holds DEPTH entries.
  always_comb begin
    fifos_full_c = 1'b1;
    for (int unsigned f = 0; f < NF; f++) begin
      if (cnt[f] != CNT_W'(DEPTH)) fifos_full_c = 1'b0;
    end
  end

  // Write handshake: only in IDLE, only to an existing, non-full FIFO.
  always_comb begin
    in_ready = 1'b0;
    if (state == S_IDLE && in_sel <= SEL_W'(LANES)) begin
      in_ready = (cnt[in_sel] < CNT_W'(DEPTH));
    end
  end

  assign wr_en_c = in_valid & in_ready;

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    acc_clr_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr) begin
          acc_clr_c = 1'b1;
        end else if (start && fifos_full_c) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        pop_c = (k < K_W'(DEPTH));
        if (k == K_W'(DEPTH + 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (clr) begin
          acc_clr_c = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_EXEC);
  assign done = (state == S_DONE);

  // State register, EXEC cycle counter, pipeline valid and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      k        <= '0;
      pvalid   <= 1'b0;
      all_full <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= (state == S_EXEC) ? k + K_W'(1) : '0;
      pvalid   <= pop_c;
      all_full <= fifos_full_c;
    end
  end

  // FIFO pointers and occupancy; pops and writes never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned f = 0; f < NF; f++) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
        cnt[f]    <= '0;
      end
    end else begin
      for (int unsigned f = 0; f < NF; f++) begin
        if (pop_c) begin
          rd_ptr[f] <= rd_ptr[f] + PTR_W'(1);
          cnt[f]    <= cnt[f] - CNT_W'(1);
        end else if (wr_en_c && in_sel == SEL_W'(f)) begin
          wr_ptr[f] <= wr_ptr[f] + PTR_W'(1);
          cnt[f]    <= cnt[f] + CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    for (int unsigned f = 0; f < NF; f++) begin
      if (wr_en_c && in_sel == SEL_W'(f)) mem[f][wr_ptr[f]] <= in_data;
    end
  end

  // Head-of-FIFO operands, widened for the multiplier.
  always_comb begin
    b_ext = op_ext(mem[LANES][rd_ptr[LANES]]);
    for (int unsigned i = 0; i < LANES; i++) begin
      a_ext[i] = op_ext(mem[i][rd_ptr[i]]);
    end
  end

  // Stage 1 product register, stage 2 accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (pop_c) prod[i] <= a_ext[i] * b_ext;
        if (acc_clr_c) begin
          acc[i] <= '0;
        end else if (pvalid) begin
          acc[i] <= acc[i] + prod_ext(prod[i]);
        end
      end
    end
  end

  // Result bus mirrors the accumulators.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_result
    assign result[gi*ACC_WIDTH +: ACC_WIDTH] = acc[gi];
  end

endmodule
